// File: rtl/lsu_mm_sched_if.sv
// Command, buffer-control and status bundle of the matmul tile scheduler.
// slave = scheduler side, master = command issuer / buffer side.
interface lsu_mm_sched_if #(
  parameter int unsigned KT_W = 4
);
  // Command channel
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [3:0]      cmd_row_len;
  logic [3:0]      cmd_col_len;
  logic [11:0]     cmd_iram_addr;
  logic [11:0]     cmd_wram_addr;
  logic [11:0]     cmd_iram_stride;
  logic [11:0]     cmd_wram_stride;
  logic [KT_W-1:0] cmd_k_tiles;

  // iram-side mm control buffer
  logic            sched_ibuf_ctrl_vld;
  logic [3:0]      sched_ibuf_ctrl_row_len;
  logic [3:0]      sched_ibuf_ctrl_col_len;
  logic [11:0]     sched_ibuf_ctrl_start_addr;
  logic            sched_ibuf_ctrl_ram_type;
  logic            ibuf_mxu_end;

  // wram-side mm control buffer
  logic            sched_wbuf_ctrl_vld;
  logic [3:0]      sched_wbuf_ctrl_row_len;
  logic [3:0]      sched_wbuf_ctrl_col_len;
  logic [11:0]     sched_wbuf_ctrl_start_addr;
  logic            sched_wbuf_ctrl_ram_type;
  logic            wbuf_mxu_end;

  // Status
  logic            sched_acc_clr;
  logic [KT_W-1:0] sched_tile_idx;
  logic            sched_busy;
  logic            sched_done;
  logic            sched_err;

  modport master (
    output cmd_vld,
    input  cmd_rdy,
    output cmd_row_len,
    output cmd_col_len,
    output cmd_iram_addr,
    output cmd_wram_addr,
    output cmd_iram_stride,
    output cmd_wram_stride,
    output cmd_k_tiles,
    input  sched_ibuf_ctrl_vld,
    input  sched_ibuf_ctrl_row_len,
    input  sched_ibuf_ctrl_col_len,
    input  sched_ibuf_ctrl_start_addr,
    input  sched_ibuf_ctrl_ram_type,
    output ibuf_mxu_end,
    input  sched_wbuf_ctrl_vld,
    input  sched_wbuf_ctrl_row_len,
    input  sched_wbuf_ctrl_col_len,
    input  sched_wbuf_ctrl_start_addr,
    input  sched_wbuf_ctrl_ram_type,
    output wbuf_mxu_end,
    input  sched_acc_clr,
    input  sched_tile_idx,
    input  sched_busy,
    input  sched_done,
    input  sched_err
  );

  modport slave (
    input  cmd_vld,
    output cmd_rdy,
    input  cmd_row_len,
    input  cmd_col_len,
    input  cmd_iram_addr,
    input  cmd_wram_addr,
    input  cmd_iram_stride,
    input  cmd_wram_stride,
    input  cmd_k_tiles,
    output sched_ibuf_ctrl_vld,
    output sched_ibuf_ctrl_row_len,
    output sched_ibuf_ctrl_col_len,
    output sched_ibuf_ctrl_start_addr,
    output sched_ibuf_ctrl_ram_type,
    input  ibuf_mxu_end,
    output sched_wbuf_ctrl_vld,
    output sched_wbuf_ctrl_row_len,
    output sched_wbuf_ctrl_col_len,
    output sched_wbuf_ctrl_start_addr,
    output sched_wbuf_ctrl_ram_type,
    input  wbuf_mxu_end,
    output sched_acc_clr,
    output sched_tile_idx,
    output sched_busy,
    output sched_done,
    output sched_err
  );
endinterface

// File: rtl/lsu_mm_sched.sv
// Matmul operand tile scheduler: launches both mm control buffers once per K tile,
// waits for both mxu_end indications, strides the start addresses and re-launches.
module lsu_mm_sched #(
  parameter int unsigned KT_W    = 4,
  parameter int unsigned TO_W    = 7,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mm_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            ctrl_vld_q, ctrl_vld_d;
  logic            acc_clr_q, acc_clr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [KT_W-1:0] tile_idx_q, tile_idx_d;
  logic [KT_W-1:0] k_tiles_q, k_tiles_d;
  logic [3:0]      row_len_q, row_len_d;
  logic [3:0]      col_len_q, col_len_d;
  logic [11:0]     iram_addr_q, iram_addr_d;
  logic [11:0]     wram_addr_q, wram_addr_d;
  logic [11:0]     iram_stride_q, iram_stride_d;
  logic [11:0]     wram_stride_q, wram_stride_d;
  logic            i_seen_q, i_seen_d;
  logic            w_seen_q, w_seen_d;
  logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;

  logic            tile_complete;
  logic            wd_expired;

  // A buffer's end may arrive before, after or together with the other one.
  assign tile_complete = (i_seen_q | bus.ibuf_mxu_end) & (w_seen_q | bus.wbuf_mxu_end);
  assign wd_expired    = (wd_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    tile_idx_d    = tile_idx_q;
    k_tiles_d     = k_tiles_q;
    row_len_d     = row_len_q;
    col_len_d     = col_len_q;
    iram_addr_d   = iram_addr_q;
    wram_addr_d   = wram_addr_q;
    iram_stride_d = iram_stride_q;
    wram_stride_d = wram_stride_q;
    i_seen_d      = i_seen_q;
    w_seen_d      = w_seen_q;
    wd_cnt_d      = wd_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_vld) begin
          row_len_d     = bus.cmd_row_len;
          col_len_d     = bus.cmd_col_len;
          iram_addr_d   = bus.cmd_iram_addr;
          wram_addr_d   = bus.cmd_wram_addr;
          iram_stride_d = bus.cmd_iram_stride;
          wram_stride_d = bus.cmd_wram_stride;
          k_tiles_d     = bus.cmd_k_tiles;
          tile_idx_d    = '0;
          err_d         = 1'b0;
          state_d       = StRun;
        end
      end
      StRun: begin
        i_seen_d = i_seen_q | bus.ibuf_mxu_end;
        w_seen_d = w_seen_q | bus.wbuf_mxu_end;
        wd_cnt_d = wd_cnt_q + TO_W'(1);
        if (tile_complete) begin
          if (tile_idx_q == k_tiles_q) begin
            state_d = StDone;
          end else begin
            iram_addr_d = iram_addr_q + iram_stride_q;
            wram_addr_d = wram_addr_q + wram_stride_q;
            tile_idx_d  = tile_idx_q + KT_W'(1);
            state_d     = StGap;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StGap: begin
        state_d = StRun;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Every tile starts with fresh end flags and a fresh watchdog.
    if ((state_d == StRun) && (state_q != StRun)) begin
      i_seen_d = 1'b0;
      w_seen_d = 1'b0;
      wd_cnt_d = '0;
    end

    cmd_rdy_d  = (state_d == StIdle);
    ctrl_vld_d = (state_d == StRun);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    acc_clr_d  = (state_q == StIdle) && (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cmd_rdy_q     <= 1'b1;
      ctrl_vld_q    <= 1'b0;
      acc_clr_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tile_idx_q    <= '0;
      k_tiles_q     <= '0;
      row_len_q     <= '0;
      col_len_q     <= '0;
      iram_addr_q   <= '0;
      wram_addr_q   <= '0;
      iram_stride_q <= '0;
      wram_stride_q <= '0;
      i_seen_q      <= 1'b0;
      w_seen_q      <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      cmd_rdy_q     <= cmd_rdy_d;
      ctrl_vld_q    <= ctrl_vld_d;
      acc_clr_q     <= acc_clr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      tile_idx_q    <= tile_idx_d;
      k_tiles_q     <= k_tiles_d;
      row_len_q     <= row_len_d;
      col_len_q     <= col_len_d;
      iram_addr_q   <= iram_addr_d;
      wram_addr_q   <= wram_addr_d;
      iram_stride_q <= iram_stride_d;
      wram_stride_q <= wram_stride_d;
      i_seen_q      <= i_seen_d;
      w_seen_q      <= w_seen_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign bus.cmd_rdy                    = cmd_rdy_q;

  assign bus.sched_ibuf_ctrl_vld        = ctrl_vld_q;
  assign bus.sched_ibuf_ctrl_row_len    = row_len_q;
  assign bus.sched_ibuf_ctrl_col_len    = col_len_q;
  assign bus.sched_ibuf_ctrl_start_addr = iram_addr_q;
  assign bus.sched_ibuf_ctrl_ram_type   = 1'b1;

  assign bus.sched_wbuf_ctrl_vld        = ctrl_vld_q;
  assign bus.sched_wbuf_ctrl_row_len    = row_len_q;
  assign bus.sched_wbuf_ctrl_col_len    = col_len_q;
  assign bus.sched_wbuf_ctrl_start_addr = wram_addr_q;
  assign bus.sched_wbuf_ctrl_ram_type   = 1'b0;

  assign bus.sched_acc_clr              = acc_clr_q;
  assign bus.sched_tile_idx             = tile_idx_q;
  assign bus.sched_busy                 = busy_q;
  assign bus.sched_done                 = done_q;
  assign bus.sched_err                  = err_q;

endmodule

// File: doc/lsu_mm_sched.md
Name: lsu_mm_sched

Overview:
Tile scheduler for the matrix-multiply operand path. It accepts one matmul command and sequences the iram-side and wram-side mm control buffers over K tiles. For each tile it drives both buffers' ctrl interface (vld, row/col len, start address, ram type) and waits for both mxu_end indications. It then advances the start addresses by per-operand strides and re-launches. It also provides MXU accumulator-clear, busy, done and a watchdog error.

Parameters:
KT_W, 4, width of tile-count field (max K tiles = 2^KT_W)
TO_W, 7, width of watchdog counter
TIMEOUT, 64, max cycles in RUN per tile before abort (must be < 2^TO_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready (high only in IDLE)
cmd_row_len  in  4  rows-1 per tile
cmd_col_len  in  4  cols-1 per tile
cmd_iram_addr  in  12  iram byte start address, tile 0
cmd_wram_addr  in  12  wram byte start address, tile 0
cmd_iram_stride  in  12  iram address increment per tile
cmd_wram_stride  in  12  wram address increment per tile
cmd_k_tiles  in  KT_W  number of tiles minus 1
sched_ibuf_ctrl_vld  out  1  iram buffer ctrl valid
sched_ibuf_ctrl_row_len  out  4  to iram buffer
sched_ibuf_ctrl_col_len  out  4  to iram buffer
sched_ibuf_ctrl_start_addr  out  12  to iram buffer
sched_ibuf_ctrl_ram_type  out  1  constant 1
ibuf_mxu_end  in  1  iram buffer finished tile
sched_wbuf_ctrl_vld  out  1  wram buffer ctrl valid
sched_wbuf_ctrl_row_len  out  4  to wram buffer
sched_wbuf_ctrl_col_len  out  4  to wram buffer
sched_wbuf_ctrl_start_addr  out  12  to wram buffer
sched_wbuf_ctrl_ram_type  out  1  constant 0
wbuf_mxu_end  in  1  wram buffer finished tile
sched_acc_clr  out  1  1-cycle pulse, first RUN cycle of tile 0
sched_tile_idx  out  KT_W  current tile index
sched_busy  out  1  high when state != IDLE
sched_done  out  1  1-cycle pulse on normal completion
sched_err  out  1  sticky watchdog error

Behaviour:
- States: IDLE, RUN, GAP, DONE. Reset → IDLE, all outputs 0 except cmd_rdy=1 and ram_type constants. All regs clear, including sched_err.
- IDLE: cmd_rdy=1. On cmd_vld at edge T:
  - capture all cmd fields and clear sched_err;
  - tile_idx=0;
  - go to RUN at T+1.
- RUN:
  - both ctrl_vld=1; row/col len from captured values; start_addr = current iram/wram address registers.
  - Sticky flags i_seen/w_seen set on ibuf_mxu_end/wbuf_mxu_end. Both are cleared on entry to RUN.
  - Completion condition = (i_seen|ibuf_mxu_end) & (w_seen|wbuf_mxu_end). Simultaneous ends in one cycle qualify.
  - On completion with tile_idx==k_tiles → DONE.
  - On completion otherwise → GAP; iram_addr+=iram_stride, wram_addr+=wram_stride (mod 4096, carry dropped); tile_idx+=1.
- GAP: exactly 1 cycle with both ctrl_vld=0, so the buffers see a fresh rising edge. Then → RUN.
- DONE: sched_done=1 for one cycle, ctrl_vld=0 → IDLE. Next command accepted at the earliest in the following cycle.
- ctrl_vld deasserts in the cycle after completion is detected. mxu_end inputs are ignored outside RUN.
- sched_acc_clr=1 only in the first RUN cycle with tile_idx==0.
- Watchdog: counter clears on RUN entry and increments each RUN cycle. If it reaches TIMEOUT without completion:
  - sched_err=1 (sticky until next cmd accept);
  - ctrl_vld=0 next cycle, state → IDLE;
  - sched_done not asserted.
- Completion and timeout in the same cycle: completion wins.
- Reset mid-operation: next cycle IDLE, ctrl_vld=0, no done pulse.
- cmd fields are don't-care outside the IDLE accept cycle. Outputs are fully registered; no combinational path from mxu_end to ctrl_vld.

Test Plan:
- Single tile: row=3, col=3, iaddr=0x040, waddr=0x100, k=0; ends asserted 8 cycles apart → ctrl_vld high from T+1 until cycle after later end; acc_clr once; done 1 cycle later; busy low after.
- Three tiles: k=2, strides 0x040/0x010, simultaneous ends → start addrs 0x040,0x080,0x0C0 (iram) and 0x100,0x110,0x120 (wram); one-cycle vld gap between tiles; tile_idx 0,1,2; acc_clr only on tile 0.
- Address wrap: iaddr=0xFC0, stride 0x080, k=1 → second tile iram start_addr 0x040.
- Watchdog: withhold wbuf_mxu_end → err=1 at 64th RUN cycle, vld drops next cycle, no done; new cmd clears err and runs normally.
- Ends outside RUN: pulse ibuf_mxu_end in IDLE/GAP → ignored, tile not shortened.
- Reset in RUN of tile 1 → next cycle IDLE, all vld 0, cmd_rdy=1, tile_idx 0.
